// File: rtl/kx4_capmux_pkg.sv
// Shared definitions for the capture-macro bus distributor: FSM encoding and
// the macro-side data width.
package kx4_capmux_pkg;

   localparam logic [1:0] KX4_ST_IDLE   = 2'd0;
   localparam logic [1:0] KX4_ST_SETUP  = 2'd1;
   localparam logic [1:0] KX4_ST_ACCESS = 2'd2;
   localparam logic [1:0] KX4_ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = KX4_ST_IDLE,
      ST_SETUP  = KX4_ST_SETUP,
      ST_ACCESS = KX4_ST_ACCESS,
      ST_DONE   = KX4_ST_DONE
   } kx4_state_t;

   localparam int KX4_BBDW = 16;

endpackage

// File: rtl/kx4_capdist4_tocnt.sv
// Wait-cycle counter for the ACCESS phase: cleared in SETUP, counts while the
// macros stall, saturates at TOUT and flags hit once the limit is reached.
module kx4_capdist4_tocnt #(
   parameter int TOUT = 15,
   parameter int TOW  = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic hit
);

   logic [TOW-1:0] cnt_reg;

   assign hit = (cnt_reg == TOW'(TOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en && !hit) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/kx4_capdist4.sv
// Request-side distributor: turns one CPU access into a setup/access
// transaction toward the left or right capture macro group.
module kx4_capdist4
   import kx4_capmux_pkg::*;
#(
   parameter int AW   = 8,
   parameter int TOUT = 15,
   parameter int TOW  = 8
) (
   input  logic                PCLK,
   input  logic                RESB,
   input  logic                REQ,
   input  logic                WR,
   input  logic [AW-1:0]       ADDR,
   input  logic [KX4_BBDW-1:0] WDATA,
   output logic                ACK,
   output logic                ERR,
   output logic [KX4_BBDW-1:0] RDATA,
   output logic                BUSY,
   output logic                BBPSELL,
   output logic                BBPSELR,
   output logic                BBPENABLE,
   output logic                BBPWRITE,
   output logic [AW-2:0]       BBPADDR,
   output logic [KX4_BBDW-1:0] BBPWDATA,
   input  logic [KX4_BBDW-1:0] BBPRDATA,
   input  logic                BBWAITMEM
);

   kx4_state_t state_reg;
   logic       cnt_clr;
   logic       cnt_en;
   logic       cnt_hit;

   assign cnt_clr = (state_reg == ST_SETUP);
   assign cnt_en  = (state_reg == ST_ACCESS) && BBWAITMEM;

   kx4_capdist4_tocnt #(
      .TOUT (TOUT),
      .TOW  (TOW)
   ) u_tocnt (
      .clk   (PCLK),
      .rst_n (RESB),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .hit   (cnt_hit)
   );

   always_ff @(posedge PCLK or negedge RESB) begin
      if (!RESB) begin
         state_reg <= ST_IDLE;
         ACK       <= 1'b0;
         ERR       <= 1'b0;
         RDATA     <= '0;
         BUSY      <= 1'b0;
         BBPSELL   <= 1'b0;
         BBPSELR   <= 1'b0;
         BBPENABLE <= 1'b0;
         BBPWRITE  <= 1'b0;
         BBPADDR   <= '0;
         BBPWDATA  <= '0;
      end else begin
         ACK <= 1'b0;
         ERR <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (REQ) begin
                  BBPWRITE  <= WR;
                  BBPADDR   <= ADDR[AW-2:0];
                  BBPWDATA  <= WDATA;
                  BBPSELL   <= ~ADDR[AW-1];
                  BBPSELR   <= ADDR[AW-1];
                  BUSY      <= 1'b1;
                  state_reg <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               BBPENABLE <= 1'b1;
               state_reg <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // Either a completed access or an abort closes the bus phase;
               // only a completed read updates RDATA.
               if (!BBWAITMEM || cnt_hit) begin
                  if (!BBWAITMEM && !BBPWRITE) begin
                     RDATA <= BBPRDATA;
                  end
                  ERR       <= BBWAITMEM;
                  ACK       <= 1'b1;
                  BBPSELL   <= 1'b0;
                  BBPSELR   <= 1'b0;
                  BBPENABLE <= 1'b0;
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               BUSY      <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kx4_capdist4.sv
// Scoreboard bench for kx4_capdist4: a reactive macro model drives the merged
// return path, expected completions are queued at request time.
module tb_kx4_capdist4;

   localparam int AW   = 8;
   localparam int TOUT = 15;
   localparam int TOW  = 8;

   logic        PCLK = 1'b0;
   logic        RESB = 1'b0;
   logic        REQ = 1'b0;
   logic        WR = 1'b0;
   logic [7:0]  ADDR = '0;
   logic [15:0] WDATA = '0;
   logic        ACK, ERR, BUSY;
   logic [15:0] RDATA;
   logic        BBPSELL, BBPSELR, BBPENABLE, BBPWRITE;
   logic [6:0]  BBPADDR;
   logic [15:0] BBPWDATA;
   logic [15:0] BBPRDATA = '0;
   logic        BBWAITMEM = 1'b0;

   kx4_capdist4 #(.AW(AW), .TOUT(TOUT), .TOW(TOW)) dut (
      .PCLK      (PCLK),
      .RESB      (RESB),
      .REQ       (REQ),
      .WR        (WR),
      .ADDR      (ADDR),
      .WDATA     (WDATA),
      .ACK       (ACK),
      .ERR       (ERR),
      .RDATA     (RDATA),
      .BUSY      (BUSY),
      .BBPSELL   (BBPSELL),
      .BBPSELR   (BBPSELR),
      .BBPENABLE (BBPENABLE),
      .BBPWRITE  (BBPWRITE),
      .BBPADDR   (BBPADDR),
      .BBPWDATA  (BBPWDATA),
      .BBPRDATA  (BBPRDATA),
      .BBWAITMEM (BBWAITMEM)
   );

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdat;
      int          waits;
      logic        exp_err;
      logic [15:0] exp_rdata;
      int          ack_edge;
   } txn_t;

   txn_t        sb_q[$];
   txn_t        slv_q[$];
   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          model_free = 0;
   logic [15:0] model_rdata = '0;

   initial forever #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Macro model: WAITMEM stays high for the first `waits` access cycles.
   txn_t cur;
   bit   cur_valid = 1'b0;
   int   acc_n = 0;
   always @(negedge PCLK) begin
      if (!RESB) begin
         cur_valid = 1'b0;
         BBWAITMEM = 1'b0;
         BBPRDATA  = '0;
      end else if (BBPSELL || BBPSELR) begin
         if (!cur_valid) begin
            if (slv_q.size() == 0) begin
               check("unexpected_setup", 32'(1), 32'(0));
            end else begin
               cur       = slv_q.pop_front();
               cur_valid = 1'b1;
               acc_n     = 0;
               check("setup_enable", 32'(BBPENABLE), 32'(0));
            end
         end
         if (cur_valid) begin
            check("sel_side", 32'({BBPSELL, BBPSELR}), 32'({~cur.addr[7], cur.addr[7]}));
            check("bbpaddr", 32'(BBPADDR), 32'(cur.addr[6:0]));
            check("bbpwdata", 32'(BBPWDATA), 32'(cur.wdata));
            check("bbpwrite", 32'(BBPWRITE), 32'(cur.wr));
            if (BBPENABLE) begin
               acc_n++;
               BBWAITMEM = (acc_n <= cur.waits);
               BBPRDATA  = cur.rdat;
            end
         end
      end else begin
         cur_valid = 1'b0;
         BBWAITMEM = 1'b0;
         BBPRDATA  = '0;
      end
   end

   // Completion monitor
   always @(negedge PCLK) begin
      if (RESB && ACK) begin
         if (sb_q.size() == 0) begin
            check("spurious_ack", 32'(ACK), 32'(0));
         end else begin
            txn_t e;
            e = sb_q.pop_front();
            check("ack_cycle", 32'(cyc), 32'(e.ack_edge));
            check("err", 32'(ERR), 32'(e.exp_err));
            check("rdata", 32'(RDATA), 32'(e.exp_rdata));
            check("done_sel_en", 32'({BBPSELL, BBPSELR, BBPENABLE}), 32'(0));
            check("done_busy", 32'(BUSY), 32'(1));
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic access(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rdat, input int waits, input bit keep);
      txn_t t;
      int   acc;
      REQ   = 1'b1;
      WR    = wr;
      ADDR  = addr;
      WDATA = wdata;
      acc   = (cyc + 1 > model_free) ? cyc + 1 : model_free;
      t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdat = rdat; t.waits = waits;
      t.exp_err  = (waits > TOUT);
      t.ack_edge = acc + 2 + (t.exp_err ? TOUT : waits);
      if (!wr && !t.exp_err) model_rdata = rdat;
      t.exp_rdata = model_rdata;
      model_free  = t.ack_edge + 2;
      sb_q.push_back(t);
      slv_q.push_back(t);
      $display("txn %s addr=%02h wdata=%04h rdat=%04h waits=%0d accept@%0d ack@%0d err=%0b",
               wr ? "WR" : "RD", addr, wdata, rdat, waits, acc, t.ack_edge, t.exp_err);
      while (cyc < acc) @(negedge PCLK);
      check("busy_rise", 32'(BUSY), 32'(1));
      if (!keep) REQ = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 100) begin
         @(negedge PCLK);
         t++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", 32'(sb_q.size()), 32'(0));
         sb_q.delete();
         slv_q.delete();
      end
      @(negedge PCLK);
      check("idle_busy", 32'({BUSY, ACK}), 32'(0));
   endtask

   initial begin
      repeat (20000) @(posedge PCLK);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge PCLK);
      check("rst_ctrl", 32'({ACK, ERR, BUSY, BBPSELL, BBPSELR, BBPENABLE, BBPWRITE}), 32'(0));
      check("rst_data", 32'({RDATA, BBPWDATA}), 32'(0));
      check("rst_addr", 32'(BBPADDR), 32'(0));
      RESB = 1'b1;
      @(negedge PCLK);

      access(1'b0, 8'h12, 16'h0000, 16'hA5C3, 0, 1'b0);     // read L, zero wait
      wait_drain();
      access(1'b1, 8'h85, 16'h1234, 16'hFFFF, 3, 1'b0);     // write R, 3 waits
      wait_drain();
      access(1'b0, 8'h33, 16'h0000, 16'h7777, 200, 1'b0);   // stuck wait -> abort
      wait_drain();
      access(1'b0, 8'hC4, 16'h0000, 16'h0F0F, TOUT, 1'b0);  // last wait before limit
      wait_drain();

      // REQ held high across four accesses
      access(1'b0, 8'h01, 16'h0000, 16'h1111, 0, 1'b1);
      access(1'b1, 8'hFE, 16'hBEAD, 16'h0000, 0, 1'b1);
      access(1'b0, 8'h80, 16'h0000, 16'h2222, 1, 1'b1);
      access(1'b1, 8'h7F, 16'hCAFE, 16'h0000, 0, 1'b0);
      wait_drain();

      // REQ pulse while busy is ignored
      access(1'b0, 8'h21, 16'h0000, 16'h3C3C, 2, 1'b0);
      @(negedge PCLK);
      REQ = 1'b1; WR = 1'b1; ADDR = 8'hF0;
      @(negedge PCLK);
      REQ = 1'b0;
      wait_drain();
      repeat (4) @(negedge PCLK);

      // Reset in the middle of a read access
      access(1'b0, 8'h44, 16'h0000, 16'hBEEF, 10, 1'b0);
      repeat (2) @(negedge PCLK);
      RESB = 1'b0;
      #1;
      check("midrst_ctrl", 32'({ACK, ERR, BUSY, BBPSELL, BBPSELR, BBPENABLE, BBPWRITE}), 32'(0));
      check("midrst_data", 32'({RDATA, BBPWDATA}), 32'(0));
      check("midrst_addr", 32'(BBPADDR), 32'(0));
      sb_q.delete();
      slv_q.delete();
      model_rdata = '0;
      repeat (2) @(negedge PCLK);
      RESB = 1'b1;
      model_free = 0;
      repeat (3) @(negedge PCLK);
      check("post_rst_idle", 32'({ACK, BUSY, BBPSELL, BBPSELR}), 32'(0));
      access(1'b0, 8'h9A, 16'h0000, 16'h5A5A, 1, 1'b0);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
